// File: rtl/ucode_seq.sv
// Microcode sequencer: FETCH reads the control store, and the control word appears one cycle later (EXEC).
// Stalls in WAIT until mem_ready/ir_valid allow it, parks in HALT until resume, and otherwise requests the next MPC.
module ucode_seq #(
    parameter int ADDR_W = 10,
    parameter int OP_W   = 8,
    parameter int CW_W   = 16,
    parameter int UI_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       mpc_addr,
    input  logic [OP_W-1:0]   ir_opcode,
    input  logic              ir_valid,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              mem_ready,
    input  logic              resume,
    input  logic              cs_we,
    input  logic [ADDR_W-1:0] cs_waddr,
    input  logic [UI_W-1:0]   cs_wdata,
    input  logic              map_we,
    input  logic [OP_W-1:0]   map_waddr,
    input  logic [ADDR_W-1:0] map_wdata,
    output logic              mpc_en,
    output logic [1:0]        mpc_sel,
    output logic [15:0]       mpc_map_addr,
    output logic [15:0]       mpc_next_addr,
    output logic [CW_W-1:0]   ctrl_word,
    output logic              ctrl_valid,
    output logic              halted
);

    typedef enum logic [1:0] {FETCH, EXEC, WAIT, HALT} state_t;

    localparam logic [1:0] SEQ_JUMP  = 2'b00;
    localparam logic [1:0] SEQ_DISP  = 2'b01;
    localparam logic [1:0] SEQ_RST   = 2'b10;
    localparam logic [1:0] SEQ_BRNCH = 2'b11;

    logic [UI_W-1:0]   cs_mem  [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] map_mem [0:(1<<OP_W)-1];

    state_t            state;
    logic [UI_W-1:0]   uinst;
    logic [ADDR_W-1:0] mpc_lo;
    logic [ADDR_W-1:0] mpc_inc;
    logic [ADDR_W-1:0] nxt;
    logic              unused_mpc_hi;

    logic [1:0]        u_seq;
    logic [1:0]        u_cond;
    logic              u_wait;
    logic              u_halt;
    logic [ADDR_W-1:0] u_next;
    logic              cond_true;
    logic              go;

    assign mpc_lo        = mpc_addr[ADDR_W-1:0];
    assign mpc_inc       = mpc_lo + 1'b1;
    assign unused_mpc_hi = ^mpc_addr[15:ADDR_W];

    assign u_seq  = uinst[UI_W-1 -: 2];
    assign u_cond = uinst[UI_W-3 -: 2];
    assign u_wait = uinst[UI_W-5];
    assign u_halt = uinst[UI_W-6];
    assign u_next = uinst[CW_W +: ADDR_W];

    // Storage has no reset; writes land at the edge, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (cs_we)
            cs_mem[cs_waddr] <= cs_wdata;
        if (map_we)
            map_mem[map_waddr] <= map_wdata;
    end

    assign mpc_map_addr = {{(16-ADDR_W){1'b0}}, map_mem[ir_opcode]};

    always_comb begin
        cond_true = 1'b1;
        case (u_cond)
            2'b00:   cond_true = flag_z;
            2'b01:   cond_true = flag_c;
            2'b10:   cond_true = ~flag_z;
            default: cond_true = 1'b1;
        endcase
    end

    assign go = (~u_wait | mem_ready) & ((u_seq != SEQ_DISP) | ir_valid);

    always_comb begin
        mpc_en  = 1'b0;
        mpc_sel = 2'b00;
        nxt     = '0;
        case (state)
            EXEC, WAIT: begin
                mpc_en = go & ~u_halt;
                case (u_seq)
                    SEQ_JUMP:  begin mpc_sel = 2'b10; nxt = u_next; end
                    SEQ_DISP:  begin mpc_sel = 2'b11; nxt = mpc_inc; end
                    SEQ_RST:   begin mpc_sel = 2'b00; nxt = '0;      end
                    SEQ_BRNCH: begin mpc_sel = 2'b10; nxt = cond_true ? u_next : mpc_inc; end
                    default:   begin mpc_sel = 2'b00; nxt = '0;      end
                endcase
            end
            HALT:    mpc_en = resume;
            default: mpc_en = 1'b0;
        endcase
    end

    assign mpc_next_addr = {{(16-ADDR_W){1'b0}}, nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            uinst      <= '0;
            ctrl_word  <= '0;
            ctrl_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    uinst      <= cs_mem[mpc_lo];
                    ctrl_word  <= cs_mem[mpc_lo][CW_W-1:0];
                    ctrl_valid <= 1'b1;
                    state      <= EXEC;
                end
                EXEC: begin
                    ctrl_valid <= 1'b0;
                    if (u_halt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (go) begin
                        state <= FETCH;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (go)
                        state <= FETCH;
                end
                HALT: begin
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ucode_seq.sv
// Bench for ucode_seq: the bench acts as the MPC register and predicts each microinstruction's outputs
// from a word-level model of the control store and map table.
module tb_ucode_seq;

    localparam int ADDR_W = 10;
    localparam int OP_W   = 8;
    localparam int CW_W   = 16;
    localparam int UI_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       mpc_addr = '0;
    logic [OP_W-1:0]   ir_opcode = '0;
    logic              ir_valid = 1'b0;
    logic              flag_z = 1'b0;
    logic              flag_c = 1'b0;
    logic              mem_ready = 1'b0;
    logic              resume = 1'b0;
    logic              cs_we = 1'b0;
    logic [ADDR_W-1:0] cs_waddr = '0;
    logic [UI_W-1:0]   cs_wdata = '0;
    logic              map_we = 1'b0;
    logic [OP_W-1:0]   map_waddr = '0;
    logic [ADDR_W-1:0] map_wdata = '0;
    logic              mpc_en;
    logic [1:0]        mpc_sel;
    logic [15:0]       mpc_map_addr;
    logic [15:0]       mpc_next_addr;
    logic [CW_W-1:0]   ctrl_word;
    logic              ctrl_valid;
    logic              halted;

    always #5 clk = ~clk;

    ucode_seq #(.ADDR_W(ADDR_W), .OP_W(OP_W), .CW_W(CW_W), .UI_W(UI_W)) dut (
        .clk(clk), .rst_n(rst_n), .mpc_addr(mpc_addr), .ir_opcode(ir_opcode),
        .ir_valid(ir_valid), .flag_z(flag_z), .flag_c(flag_c), .mem_ready(mem_ready),
        .resume(resume), .cs_we(cs_we), .cs_waddr(cs_waddr), .cs_wdata(cs_wdata),
        .map_we(map_we), .map_waddr(map_waddr), .map_wdata(map_wdata),
        .mpc_en(mpc_en), .mpc_sel(mpc_sel), .mpc_map_addr(mpc_map_addr),
        .mpc_next_addr(mpc_next_addr), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
        .halted(halted)
    );

    logic [UI_W-1:0]   cs_model  [1024];
    logic [ADDR_W-1:0] map_model [256];
    logic [ADDR_W-1:0] mpc;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [UI_W-1:0] mk(input logic [1:0] seq, input logic [1:0] cnd,
                                           input logic wm, input logic hb,
                                           input logic [ADDR_W-1:0] nx, input logic [CW_W-1:0] cw);
        return {seq, cnd, wm, hb, nx, cw};
    endfunction

    // Writes are issued while rst_n is low so the sequencer stays parked in FETCH.
    task automatic wr_cs(input logic [ADDR_W-1:0] a, input logic [UI_W-1:0] d);
        cs_we = 1'b1; cs_waddr = a; cs_wdata = d; cs_model[a] = d;
        @(posedge clk); #1;
        cs_we = 1'b0;
    endtask

    task automatic wr_map(input logic [OP_W-1:0] a, input logic [ADDR_W-1:0] d);
        map_we = 1'b1; map_waddr = a; map_wdata = d; map_model[a] = d;
        @(posedge clk); #1;
        map_we = 1'b0;
    endtask

    // Entered and left at posedge+1 with the DUT in FETCH for mpc.
    task automatic run_instr(input int hold, input int fz, input int op);
        logic [UI_W-1:0]   ui;
        logic [1:0]        seq, cnd;
        logic              wm, hb, go, taken;
        logic [ADDR_W-1:0] nx, tgt;
        logic [CW_W-1:0]   cw;
        logic [1:0]        exp_sel;
        int                k;
        bit                done;
        ui  = cs_model[mpc];
        seq = ui[31:30]; cnd = ui[29:28]; wm = ui[27]; hb = ui[26];
        nx  = ui[25:16]; cw = ui[15:0];
        mpc_addr  = {6'($urandom), mpc};
        flag_z    = 1'($urandom); flag_c = 1'($urandom);
        ir_valid  = 1'($urandom); mem_ready = 1'($urandom);
        resume    = 1'b0;
        @(negedge clk);
        check("fetch_en", mpc_en, 0);
        check("fetch_sel", mpc_sel, 0);
        check("fetch_next", mpc_next_addr, 0);
        check("fetch_cvalid", ctrl_valid, 0);
        check("fetch_halted", halted, 0);
        @(posedge clk); #1;
        k = 0; done = 0;
        while (!done) begin
            if (k < hold) begin
                ir_valid = 1'b0; mem_ready = 1'b0;
            end else if ((hold > 0 && k == hold) || k >= 8) begin
                ir_valid = 1'b1; mem_ready = 1'b1;
            end else begin
                ir_valid = 1'($urandom); mem_ready = 1'($urandom);
            end
            flag_z    = (fz < 0) ? 1'($urandom) : fz[0];
            flag_c    = 1'($urandom);
            ir_opcode = (op < 0) ? OP_W'($urandom) : op[OP_W-1:0];
            @(negedge clk);
            check("ctrl_word", ctrl_word, cw);
            check("ctrl_valid", ctrl_valid, k == 0);
            check("map_addr", mpc_map_addr, {6'b0, map_model[ir_opcode]});
            check("halted_run", halted, 0);
            if (hb) begin
                check("halt_en", mpc_en, 0);
                @(posedge clk); #1;
                repeat ($urandom_range(1, 4)) begin
                    mem_ready = 1'($urandom); ir_valid = 1'($urandom); resume = 1'b0;
                    @(negedge clk);
                    check("halt_halted", halted, 1);
                    check("halt_en_idle", mpc_en, 0);
                    check("halt_cvalid", ctrl_valid, 0);
                    check("halt_cword", ctrl_word, cw);
                    @(posedge clk); #1;
                end
                resume = 1'b1;
                @(negedge clk);
                check("resume_en", mpc_en, 1);
                check("resume_sel", mpc_sel, 0);
                @(posedge clk); #1;
                resume = 1'b0;
                mpc = '0;
                done = 1;
            end else begin
                go = (!wm || mem_ready) && (seq != 2'b01 || ir_valid);
                check("mpc_en", mpc_en, go);
                if (go) begin
                    case (cnd)
                        2'b00:   taken = flag_z;
                        2'b01:   taken = flag_c;
                        2'b10:   taken = !flag_z;
                        default: taken = 1'b1;
                    endcase
                    case (seq)
                        2'b00:   begin exp_sel = 2'b10; tgt = nx; end
                        2'b01:   begin exp_sel = 2'b11; tgt = map_model[ir_opcode]; end
                        2'b10:   begin exp_sel = 2'b00; tgt = '0; end
                        default: begin exp_sel = 2'b10; tgt = taken ? nx : ADDR_W'((mpc + 1) % 1024); end
                    endcase
                    check("mpc_sel", mpc_sel, exp_sel);
                    if (exp_sel == 2'b10) check("next_addr", mpc_next_addr, {6'b0, tgt});
                    mpc  = tgt;
                    done = 1;
                end
                @(posedge clk); #1;
                k++;
            end
        end
    endtask

    int hold_t [11] = '{0, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    int fz_t   [11] = '{-1, -1, -1, 0, -1, -1, -1, -1, 1, -1, 0};
    int op_t   [11] = '{-1, 'h12, -1, -1, -1, -1, 'h12, -1, -1, -1, -1};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_en", mpc_en, 0);
        check("rst_sel", mpc_sel, 0);
        check("rst_cword", ctrl_word, 0);
        check("rst_cvalid", ctrl_valid, 0);
        check("rst_halted", halted, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) wr_map(OP_W'(i), ADDR_W'($urandom));
        wr_map(8'h12, 10'h040);
        wr_cs(10'h000, mk(2'b00, 2'b11, 0, 0, 10'h005, 16'hA5A5));
        wr_cs(10'h005, mk(2'b01, 2'b11, 0, 0, 10'h000, 16'h1234));
        wr_cs(10'h040, mk(2'b00, 2'b11, 0, 0, 10'h007, 16'h0F0F));
        wr_cs(10'h007, mk(2'b11, 2'b00, 0, 0, 10'h020, 16'h7777));
        wr_cs(10'h008, mk(2'b00, 2'b11, 0, 1, 10'h123, 16'hDEAD));
        wr_cs(10'h020, mk(2'b00, 2'b11, 1, 0, 10'h3FF, 16'hBEEF));
        wr_cs(10'h3FF, mk(2'b11, 2'b00, 0, 0, 10'h100, 16'h4242));
        rst_n = 1'b1;
        mpc = '0;
        for (int s = 0; s < 11; s++) run_instr(hold_t[s], fz_t[s], op_t[s]);

        // Reset taken while the sequencer is stalled in WAIT.
        rst_n = 1'b0;
        wr_cs(10'h000, mk(2'b00, 2'b11, 1, 0, 10'h003, 16'h5A5A));
        rst_n = 1'b1;
        mpc_addr = '0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_cvalid", ctrl_valid, 0);
        check("wait_en", mpc_en, 0);
        check("wait_cword", ctrl_word, 16'h5A5A);
        rst_n = 1'b0;
        #1;
        check("midrst_en", mpc_en, 0);
        check("midrst_cvalid", ctrl_valid, 0);
        check("midrst_cword", ctrl_word, 0);
        check("midrst_halted", halted, 0);
        wr_cs(10'h000, mk(2'b00, 2'b11, 0, 0, 10'h009, 16'hC3C3));
        rst_n = 1'b1;
        mpc = '0;
        run_instr(0, -1, -1);

        // Random program over a fully written store.
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++)
            wr_cs(ADDR_W'(i), mk(2'($urandom), 2'($urandom), 1'($urandom),
                                 $urandom_range(0, 7) == 0, ADDR_W'($urandom), CW_W'($urandom)));
        for (int i = 0; i < 256; i++) wr_map(OP_W'(i), ADDR_W'($urandom));
        rst_n = 1'b1;
        mpc = '0;
        for (int n = 0; n < 300; n++) run_instr(0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
